// File: rtl/fft_32_frame_arbiter.sv
`default_nettype none
// ============================================================================
// fft_32_frame_arbiter : round-robin whole-frame arbiter sharing one fft_32,
// with a tag FIFO labelling each FFT output frame with its source channel.
// Revision: 1.0
// ============================================================================
module fft_32_frame_arbiter #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int MIN_FRAME_GAP  = 32,
  parameter int TAG_FIFO_DEPTH = 8
) (
  input  logic                                    Clk,
  input  logic                                    Rst,
  input  logic [NUM_CHANNELS-1:0]                 Req_valid,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] Req_i,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] Req_q,
  input  logic [NUM_CHANNELS-1:0]                 Req_last,
  output logic [NUM_CHANNELS-1:0]                 Req_ready,
  output logic                                    Fft_valid,
  output logic [DATA_WIDTH-1:0]                   Fft_i,
  output logic [DATA_WIDTH-1:0]                   Fft_q,
  output logic [4:0]                              Fft_index,
  output logic                                    Fft_last,
  input  logic                                    Fft_out_valid,
  input  logic                                    Fft_out_last,
  output logic [$clog2(NUM_CHANNELS)-1:0]         Output_channel,
  output logic                                    Output_channel_valid,
  output logic                                    Error_frame_length,
  output logic                                    Error_tag_underflow
);

  localparam int CH_W     = $clog2(NUM_CHANNELS);
  localparam int AW       = $clog2(TAG_FIFO_DEPTH);
  localparam int GAP_W    = (MIN_FRAME_GAP > 2) ? $clog2(MIN_FRAME_GAP) : 1;
  localparam int GAP_LAST = (MIN_FRAME_GAP > 1) ? MIN_FRAME_GAP - 2 : 0;
  localparam logic [CH_W:0]   NCH       = (CH_W+1)'(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CHANNELS - 1);
  localparam logic [AW:0]     FIFO_FULL = (AW+1)'(TAG_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CH_W-1:0]         gnt_q;
  logic [CH_W-1:0]         rr_q;
  logic [4:0]              cnt_q;
  logic [GAP_W-1:0]        gap_q;
  logic [NUM_CHANNELS-1:0] ready_q;
  logic                    fft_valid_q;
  logic [DATA_WIDTH-1:0]   fft_i_q;
  logic [DATA_WIDTH-1:0]   fft_q_q;
  logic [4:0]              fft_index_q;
  logic                    fft_last_q;
  logic                    err_len_q;
  logic                    err_uf_q;

  logic [CH_W-1:0]         tag_mem_q [TAG_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [AW:0]             count_q;

  logic [CH_W-1:0]         gnt_d;
  logic [CH_W-1:0]         rr_d;
  logic [CH_W:0]           rr_idx;
  logic                    found;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;
  logic                    push;
  logic                    accept;
  logic                    cnt_end;

  // First requester at or after the round-robin pointer.
  always_comb begin
    found  = 1'b0;
    gnt_d  = rr_q;
    rr_idx = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rr_idx = {1'b0, rr_q} + (CH_W+1)'(i);
      if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
      if (!found && Req_valid[rr_idx[CH_W-1:0]]) begin
        found = 1'b1;
        gnt_d = rr_idx[CH_W-1:0];
      end
    end
  end

  assign rr_d       = (gnt_d == LAST_CH) ? '0 : gnt_d + CH_W'(1);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign pop        = Fft_out_valid & Fft_out_last & ~fifo_empty;
  // A same-cycle pop frees a slot, so a full FIFO does not block that grant.
  assign push       = (state_q == S_IDLE) & found & (~fifo_full | pop);
  assign accept     = ready_q[gnt_q] & Req_valid[gnt_q];
  assign cnt_end    = (cnt_q == 5'd31);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      ready_q     <= '0;
      fft_valid_q <= 1'b0;
      fft_i_q     <= '0;
      fft_q_q     <= '0;
      fft_index_q <= '0;
      fft_last_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_uf_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int k = 0; k < TAG_FIFO_DEPTH; k++) tag_mem_q[k] <= '0;
    end else begin
      fft_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_uf_q    <= Fft_out_valid & fifo_empty;

      if (push) begin
        tag_mem_q[wr_ptr_q] <= gnt_d;
        wr_ptr_q            <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);

      case (state_q)
        S_IDLE: begin
          if (push) begin
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= '0;
            ready_q <= {{(NUM_CHANNELS-1){1'b0}}, 1'b1} << gnt_d;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            fft_valid_q <= 1'b1;
            fft_i_q     <= Req_i[gnt_q];
            fft_q_q     <= Req_q[gnt_q];
            fft_index_q <= cnt_q;
            fft_last_q  <= cnt_end;
            err_len_q   <= Req_last[gnt_q] ^ cnt_end;
            cnt_q       <= cnt_q + 5'd1;
            if (cnt_end) begin
              ready_q <= '0;
              gap_q   <= '0;
              // IDLE grant and first STREAM cycle already give two idle cycles,
              // and the first GAP cycle carries the last sample.
              state_q <= (MIN_FRAME_GAP > 1) ? S_GAP : S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_W'(GAP_LAST)) state_q <= S_IDLE;
          else                           gap_q   <= gap_q + GAP_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Req_ready            = ready_q;
  assign Fft_valid            = fft_valid_q;
  assign Fft_i                = fft_i_q;
  assign Fft_q                = fft_q_q;
  assign Fft_index            = fft_index_q;
  assign Fft_last             = fft_last_q;
  assign Output_channel       = tag_mem_q[rd_ptr_q];
  assign Output_channel_valid = ~fifo_empty;
  assign Error_frame_length   = err_len_q;
  assign Error_tag_underflow  = err_uf_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_32_frame_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fft_32_frame_arbiter : directed self-checking bench for the FFT arbiter.
// Revision: 1.0
// ============================================================================
module tb_fft_32_frame_arbiter;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic [3:0]       Req_valid;
  logic [3:0][15:0] Req_i;
  logic [3:0][15:0] Req_q;
  logic [3:0]       Req_last;
  logic [3:0]       Req_ready;
  logic             Fft_valid;
  logic [15:0]      Fft_i;
  logic [15:0]      Fft_q;
  logic [4:0]       Fft_index;
  logic             Fft_last;
  logic             Fft_out_valid = 1'b0;
  logic             Fft_out_last  = 1'b0;
  logic [1:0]       Output_channel;
  logic             Output_channel_valid;
  logic             Error_frame_length;
  logic             Error_tag_underflow;

  int checks   = 0;
  int failures = 0;
  int src_frames [4];
  int src_cnt    [4];
  int src_frm    [4];
  int src_period [4];
  int src_last_at[4];
  int phase = 0;
  bit acc_any;

  fft_32_frame_arbiter #(
    .NUM_CHANNELS  (4),
    .DATA_WIDTH    (16),
    .MIN_FRAME_GAP (32),
    .TAG_FIFO_DEPTH(8)
  ) dut (
    .Clk                 (Clk),
    .Rst                 (Rst),
    .Req_valid           (Req_valid),
    .Req_i               (Req_i),
    .Req_q               (Req_q),
    .Req_last            (Req_last),
    .Req_ready           (Req_ready),
    .Fft_valid           (Fft_valid),
    .Fft_i               (Fft_i),
    .Fft_q               (Fft_q),
    .Fft_index           (Fft_index),
    .Fft_last            (Fft_last),
    .Fft_out_valid       (Fft_out_valid),
    .Fft_out_last        (Fft_out_last),
    .Output_channel      (Output_channel),
    .Output_channel_valid(Output_channel_valid),
    .Error_frame_length  (Error_frame_length),
    .Error_tag_underflow (Error_tag_underflow)
  );

  always #5 Clk = ~Clk;

  task automatic src_init();
    for (int c = 0; c < 4; c++) begin
      src_frames[c]  = 0;
      src_cnt[c]     = 0;
      src_frm[c]     = 0;
      src_period[c]  = 1;
      src_last_at[c] = 31;
    end
    Req_valid = '0;
    Req_last  = '0;
    Req_i     = '0;
    Req_q     = '0;
  endtask

  // One clock: note handshakes before the edge, then advance the sources.
  task automatic tick();
    logic [3:0] acc;
    acc     = Req_valid & Req_ready;
    acc_any = |acc;
    @(posedge Clk);
    #1;
    phase++;
    for (int c = 0; c < 4; c++) begin
      if (acc[c]) begin
        if (src_cnt[c] == 31) begin
          src_cnt[c] = 0;
          src_frm[c]++;
          src_frames[c]--;
        end else begin
          src_cnt[c]++;
        end
      end
      Req_valid[c] = (src_frames[c] > 0) &&
                     ((Req_valid[c] && !acc[c]) || (phase % src_period[c] == 0));
      Req_i[c]     = {4'(c), 4'(src_frm[c]), 8'(src_cnt[c])};
      Req_q[c]     = ~Req_i[c];
      Req_last[c]  = (src_cnt[c] == src_last_at[c]);
    end
  endtask

  task automatic apply_reset();
    src_init();
    Fft_out_valid = 1'b0;
    Fft_out_last  = 1'b0;
    Rst = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    tick();
  endtask

  task automatic pop_tag();
    Fft_out_valid = 1'b1;
    Fft_out_last  = 1'b1;
    tick();
    Fft_out_valid = 1'b0;
    Fft_out_last  = 1'b0;
  endtask

  task automatic test_reset();
    src_init();
    Rst = 1'b0;
    tick();
    tick();
    checks++;
    if (Req_ready !== 4'b0 || Fft_valid !== 1'b0 || Fft_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b valid=%b last=%b required 0", Req_ready, Fft_valid, Fft_last);
    end
    checks++;
    if (Fft_index !== 5'd0 || Output_channel_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_index: index=%0d tagvalid=%b required 0", Fft_index, Output_channel_valid);
    end
    checks++;
    if (Error_frame_length !== 1'b0 || Error_tag_underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: len=%b uf=%b required 0", Error_frame_length, Error_tag_underflow);
    end
    Rst = 1'b1;
    tick();
    checks++;
    if (Req_ready !== 4'b0) begin
      failures++;
      $display("FAIL idle_noreq: ready=%b required 0000", Req_ready);
    end
  endtask

  task automatic test_single_ch2();
    int n = 0;
    int t = 0;
    logic [15:0] exp_i;
    src_init();
    src_frames[2] = 1;
    while (n < 32 && t < 300) begin
      tick();
      t++;
      checks++;
      if (Fft_valid !== acc_any) begin
        failures++;
        $display("FAIL ch2_latency: valid=%b required %b", Fft_valid, acc_any);
      end
      checks++;
      if ((Req_ready & 4'b1011) !== 4'b0) begin
        failures++;
        $display("FAIL ch2_ready: ready=%b required only bit2", Req_ready);
      end
      checks++;
      if (Error_frame_length !== 1'b0 || Error_tag_underflow !== 1'b0) begin
        failures++;
        $display("FAIL ch2_err: len=%b uf=%b required 0", Error_frame_length, Error_tag_underflow);
      end
      if (Fft_valid) begin
        exp_i = {4'd2, 4'd0, 8'(n)};
        checks++;
        if (Fft_index !== 5'(n) || Fft_last !== (n == 31)) begin
          failures++;
          $display("FAIL ch2_index: index=%0d last=%b required %0d %b", Fft_index, Fft_last, n, (n == 31));
        end
        checks++;
        if (Fft_i !== exp_i || Fft_q !== ~exp_i) begin
          failures++;
          $display("FAIL ch2_data: i=%h q=%h required %h %h", Fft_i, Fft_q, exp_i, ~exp_i);
        end
        n++;
      end
    end
    checks++;
    if (t >= 300) begin
      failures++;
      $display("FAIL ch2_timeout: samples=%0d required 32", n);
    end
    checks++;
    if (Output_channel !== 2'd2 || Output_channel_valid !== 1'b1) begin
      failures++;
      $display("FAIL ch2_tag: ch=%0d valid=%b required 2 1", Output_channel, Output_channel_valid);
    end
    pop_tag();
    checks++;
    if (Output_channel_valid !== 1'b0 || Error_tag_underflow !== 1'b0) begin
      failures++;
      $display("FAIL ch2_pop: valid=%b uf=%b required 0 0", Output_channel_valid, Error_tag_underflow);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] pr;
    int nlast = 0;
    int low = 0;
    int t = 0;
    int got;
    bit in_gap = 1'b0;
    apply_reset();
    src_frames[0] = 2;
    src_frames[1] = 1;
    src_frames[2] = 1;
    src_frames[3] = 1;
    while (nlast < 5 && t < 1000) begin
      pr = Req_ready;
      tick();
      t++;
      if (pr == 4'b0 && Req_ready != 4'b0)
        for (int c = 0; c < 4; c++) if (Req_ready[c]) order.push_back(c);
      checks++;
      if ($countones(Req_ready) > 1) begin
        failures++;
        $display("FAIL rr_onehot: ready=%b required at most one bit", Req_ready);
      end
      if (Fft_valid) begin
        if (in_gap) begin
          checks++;
          if (low != 32) begin
            failures++;
            $display("FAIL rr_gap: idle cycles=%0d required 32", low);
          end
          in_gap = 1'b0;
        end
        if (Fft_last) begin
          nlast++;
          in_gap = 1'b1;
          low = 0;
        end
      end else begin
        low++;
      end
    end
    checks++;
    if (t >= 1000) begin
      failures++;
      $display("FAIL rr_timeout: frames=%0d required 5", nlast);
    end
    for (int k = 0; k < 5; k++) begin
      got = (k < order.size()) ? order[k] : -1;
      checks++;
      if (got != exp_order[k]) begin
        failures++;
        $display("FAIL rr_order[%0d]: grant=%0d required %0d", k, got, exp_order[k]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (Output_channel_valid !== 1'b1 || Output_channel !== 2'(exp_order[k])) begin
        failures++;
        $display("FAIL rr_tag[%0d]: ch=%0d valid=%b required %0d 1", k, Output_channel, Output_channel_valid, exp_order[k]);
      end
      pop_tag();
    end
    checks++;
    if (Output_channel_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_empty: valid=%b required 0", Output_channel_valid);
    end
  endtask

  task automatic test_bubbles();
    int n = 0;
    int t = 0;
    src_init();
    src_frames[1] = 1;
    src_period[1] = 3;
    while (n < 32 && t < 400) begin
      tick();
      t++;
      checks++;
      if ((Req_ready & 4'b1101) !== 4'b0) begin
        failures++;
        $display("FAIL bub_ready: ready=%b required only bit1", Req_ready);
      end
      if (Fft_valid) begin
        checks++;
        if (Fft_index !== 5'(n) || Fft_last !== (n == 31)) begin
          failures++;
          $display("FAIL bub_index: index=%0d last=%b required %0d %b", Fft_index, Fft_last, n, (n == 31));
        end
        n++;
      end
    end
    checks++;
    if (t >= 400) begin
      failures++;
      $display("FAIL bub_timeout: samples=%0d required 32", n);
    end
    checks++;
    if (Output_channel !== 2'd1) begin
      failures++;
      $display("FAIL bub_tag: ch=%0d required 1", Output_channel);
    end
    pop_tag();
  endtask

  task automatic test_frame_length_error();
    int n = 0;
    int t = 0;
    src_init();
    src_frames[3]  = 1;
    src_last_at[3] = 15;
    while (n < 32 && t < 300) begin
      tick();
      t++;
      if (Fft_valid) begin
        checks++;
        if (Error_frame_length !== (n == 15 || n == 31)) begin
          failures++;
          $display("FAIL len_err[%0d]: err=%b required %b", n, Error_frame_length, (n == 15 || n == 31));
        end
        checks++;
        if (Fft_index !== 5'(n) || Fft_last !== (n == 31)) begin
          failures++;
          $display("FAIL len_index: index=%0d last=%b required %0d %b", Fft_index, Fft_last, n, (n == 31));
        end
        n++;
      end else begin
        checks++;
        if (Error_frame_length !== 1'b0) begin
          failures++;
          $display("FAIL len_idle_err: err=%b required 0", Error_frame_length);
        end
      end
    end
    checks++;
    if (t >= 300) begin
      failures++;
      $display("FAIL len_timeout: samples=%0d required 32", n);
    end
    checks++;
    if (Output_channel !== 2'd3 || Output_channel_valid !== 1'b1) begin
      failures++;
      $display("FAIL len_tag: ch=%0d valid=%b required 3 1", Output_channel, Output_channel_valid);
    end
    pop_tag();
  endtask

  task automatic test_fifo_full();
    int order[$];
    int exp_order[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    logic [3:0] pr;
    int nlast = 0;
    int t = 0;
    int bad = 0;
    int got;
    apply_reset();
    src_frames[0] = 3;
    src_frames[1] = 2;
    src_frames[2] = 2;
    src_frames[3] = 2;
    while (nlast < 8 && t < 1500) begin
      pr = Req_ready;
      tick();
      t++;
      if (pr == 4'b0 && Req_ready != 4'b0)
        for (int c = 0; c < 4; c++) if (Req_ready[c]) order.push_back(c);
      if (Fft_valid && Fft_last) nlast++;
    end
    checks++;
    if (t >= 1500) begin
      failures++;
      $display("FAIL full_timeout: frames=%0d required 8", nlast);
    end
    for (int w = 0; w < 100; w++) begin
      tick();
      if (Req_ready != 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_blocked: granted cycles=%0d required 0", bad);
    end
    checks++;
    if (Output_channel !== 2'd0 || Output_channel_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_head: ch=%0d valid=%b required 0 1", Output_channel, Output_channel_valid);
    end
    pr = Req_ready;
    pop_tag();
    if (pr == 4'b0 && Req_ready != 4'b0)
      for (int c = 0; c < 4; c++) if (Req_ready[c]) order.push_back(c);
    t = 0;
    while (nlast < 9 && t < 300) begin
      pr = Req_ready;
      tick();
      t++;
      if (pr == 4'b0 && Req_ready != 4'b0)
        for (int c = 0; c < 4; c++) if (Req_ready[c]) order.push_back(c);
      if (Fft_valid && Fft_last) nlast++;
    end
    checks++;
    if (t >= 300) begin
      failures++;
      $display("FAIL full_ninth: frames=%0d required 9", nlast);
    end
    for (int k = 0; k < 9; k++) begin
      got = (k < order.size()) ? order[k] : -1;
      checks++;
      if (got != exp_order[k]) begin
        failures++;
        $display("FAIL full_order[%0d]: grant=%0d required %0d", k, got, exp_order[k]);
      end
    end
    for (int k = 1; k < 9; k++) begin
      checks++;
      if (Output_channel_valid !== 1'b1 || Output_channel !== 2'(exp_order[k])) begin
        failures++;
        $display("FAIL full_tag[%0d]: ch=%0d valid=%b required %0d 1", k, Output_channel, Output_channel_valid, exp_order[k]);
      end
      pop_tag();
    end
    checks++;
    if (Output_channel_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_empty: valid=%b required 0", Output_channel_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t = 0;
    src_init();
    src_frames[2] = 1;
    while (!(Fft_valid && Fft_index == 5'd10) && t < 300) begin
      tick();
      t++;
    end
    checks++;
    if (t >= 300) begin
      failures++;
      $display("FAIL mid_timeout: index=%0d required 10", Fft_index);
    end
    src_init();
    src_frames[0] = 1;
    src_frames[3] = 1;
    Rst = 1'b0;
    tick();
    checks++;
    if (Req_ready !== 4'b0 || Fft_valid !== 1'b0 || Fft_last !== 1'b0 || Fft_index !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset_ctrl: ready=%b valid=%b last=%b index=%0d required 0", Req_ready, Fft_valid, Fft_last, Fft_index);
    end
    checks++;
    if (Output_channel_valid !== 1'b0 || Error_frame_length !== 1'b0 || Error_tag_underflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_tag: tagvalid=%b len=%b uf=%b required 0", Output_channel_valid, Error_frame_length, Error_tag_underflow);
    end
    Rst = 1'b1;
    t = 0;
    while (Req_ready == 4'b0 && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (Req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_priority: ready=%b required 0001", Req_ready);
    end
  endtask

  task automatic test_tag_underflow();
    src_init();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    Fft_out_valid = 1'b1;
    Fft_out_last  = 1'b1;
    tick();
    Fft_out_valid = 1'b0;
    Fft_out_last  = 1'b0;
    checks++;
    if (Error_tag_underflow !== 1'b1) begin
      failures++;
      $display("FAIL uf_pulse: uf=%b required 1", Error_tag_underflow);
    end
    checks++;
    if (Output_channel_valid !== 1'b0) begin
      failures++;
      $display("FAIL uf_nopop: tagvalid=%b required 0", Output_channel_valid);
    end
    tick();
    checks++;
    if (Error_tag_underflow !== 1'b0) begin
      failures++;
      $display("FAIL uf_one_cycle: uf=%b required 0", Error_tag_underflow);
    end
  endtask

  initial begin
    src_init();
    test_reset();
    test_single_ch2();
    test_round_robin();
    test_bubbles();
    test_frame_length_error();
    test_fifo_full();
    test_reset_mid_frame();
    test_tag_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
